// File: rtl/axi4_sram_slave.sv
// Single-beat AXI4 slave backed by a DEPTH-word register array at BASE_ADDR.
// Define AXI_SRAM_RANGE_CHECK_EN to answer out-of-range accesses with SLVERR instead of aliasing.
module axi4_sram_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   output logic [1:0]            S_AXI_BRESP,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic                  S_AXI_ARVALID,
   output logic                  S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]            S_AXI_RRESP,
   output logic                  S_AXI_RVALID,
   input  logic                  S_AXI_RREADY
);

   localparam int IDX_W   = $clog2(DEPTH);
   localparam int TOP_LSB = IDX_W + 2;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_RESP} rstate_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   wstate_t               r_wstate, w_wnext;
   rstate_t               r_rstate, w_rnext;
   logic [IDX_W-1:0]      r_widx;
   logic                  r_wok;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [1:0]            r_bresp;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;

   logic [IDX_W-1:0]      w_aw_idx, w_ar_idx, w_commit_idx;
   logic                  w_aw_ok, w_ar_ok, w_commit_ok, w_commit;
   logic [DATA_WIDTH-1:0] w_commit_data;
   logic                  w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
   logic                  w_unused;

   assign w_aw_idx = S_AXI_AWADDR[TOP_LSB-1:2];
   assign w_ar_idx = S_AXI_ARADDR[TOP_LSB-1:2];

`ifdef AXI_SRAM_RANGE_CHECK_EN
   // BASE_ADDR is aligned to DEPTH*4, so range membership is an upper-bit match.
   assign w_aw_ok  = (S_AXI_AWADDR[ADDR_WIDTH-1:TOP_LSB] == BASE_ADDR[ADDR_WIDTH-1:TOP_LSB]);
   assign w_ar_ok  = (S_AXI_ARADDR[ADDR_WIDTH-1:TOP_LSB] == BASE_ADDR[ADDR_WIDTH-1:TOP_LSB]);
   assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
   assign w_aw_ok  = 1'b1;
   assign w_ar_ok  = 1'b1;
   assign w_unused = ^{S_AXI_AWADDR[ADDR_WIDTH-1:TOP_LSB], S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[ADDR_WIDTH-1:TOP_LSB], S_AXI_ARADDR[1:0]};
`endif

   // A transfer happens on a rising edge where VALID and READY are both high;
   // VALID/payload of a response never change until its READY is seen.
   always_comb begin
      w_wnext       = r_wstate;
      w_awready     = 1'b0;
      w_wready      = 1'b0;
      w_bvalid      = 1'b0;
      w_commit      = 1'b0;
      w_commit_idx  = w_aw_idx;
      w_commit_ok   = w_aw_ok;
      w_commit_data = S_AXI_WDATA;
      case (r_wstate)
         W_IDLE: begin
            w_awready = 1'b1;
            w_wready  = 1'b1;
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
               w_commit = 1'b1;
               w_wnext  = W_RESP;
            end else if (S_AXI_AWVALID) begin
               w_wnext = W_ADDR;
            end else if (S_AXI_WVALID) begin
               w_wnext = W_DATA;
            end
         end
         W_ADDR: begin
            w_wready     = 1'b1;
            w_commit_idx = r_widx;
            w_commit_ok  = r_wok;
            if (S_AXI_WVALID) begin
               w_commit = 1'b1;
               w_wnext  = W_RESP;
            end
         end
         W_DATA: begin
            w_awready     = 1'b1;
            w_commit_data = r_wdata;
            if (S_AXI_AWVALID) begin
               w_commit = 1'b1;
               w_wnext  = W_RESP;
            end
         end
         W_RESP: begin
            w_bvalid = 1'b1;
            if (S_AXI_BREADY) w_wnext = W_IDLE;
         end
         default: w_wnext = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wstate <= W_IDLE;
         r_bresp  <= 2'b00;
         r_widx   <= '0;
         r_wok    <= 1'b0;
         r_wdata  <= '0;
      end else begin
         r_wstate <= w_wnext;
         if (S_AXI_AWVALID && w_awready) begin
            r_widx <= w_aw_idx;
            r_wok  <= w_aw_ok;
         end
         if (S_AXI_WVALID && w_wready) r_wdata <= S_AXI_WDATA;
         if (w_commit) r_bresp <= w_commit_ok ? 2'b00 : 2'b10;
      end
   end

   // Array is deliberately left out of reset so contents survive it.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && w_commit_ok) r_mem[w_commit_idx] <= w_commit_data;
   end

   always_comb begin
      w_rnext   = r_rstate;
      w_arready = 1'b0;
      w_rvalid  = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            w_arready = 1'b1;
            if (S_AXI_ARVALID) w_rnext = R_RESP;
         end
         R_RESP: begin
            w_rvalid = 1'b1;
            if (S_AXI_RREADY) w_rnext = R_IDLE;
         end
         default: w_rnext = R_IDLE;
      endcase
   end

   // Sampling r_mem here sees pre-edge contents, so a colliding write returns old data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rstate <= R_IDLE;
         r_rdata  <= '0;
         r_rresp  <= 2'b00;
      end else begin
         r_rstate <= w_rnext;
         if (S_AXI_ARVALID && w_arready) begin
            r_rdata <= w_ar_ok ? r_mem[w_ar_idx] : '0;
            r_rresp <= w_ar_ok ? 2'b00 : 2'b10;
         end
      end
   end

   assign S_AXI_AWREADY = w_awready & ~rst;
   assign S_AXI_WREADY  = w_wready  & ~rst;
   assign S_AXI_BVALID  = w_bvalid  & ~rst;
   assign S_AXI_BRESP   = rst ? 2'b00 : r_bresp;
   assign S_AXI_ARREADY = w_arready & ~rst;
   assign S_AXI_RVALID  = w_rvalid  & ~rst;
   assign S_AXI_RRESP   = rst ? 2'b00 : r_rresp;
   assign S_AXI_RDATA   = rst ? '0 : r_rdata;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave (BASE_ADDR=0x1000, DEPTH=256); honours AXI_SRAM_RANGE_CHECK_EN.
module tb_axi4_sram_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q[$];

   axi4_sram_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0000_1000)
   ) dut (
      .clk(clk), .rst(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   // AW and W together; BREADY held low for 'stall' cycles after BVALID.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                           input int stall);
      @(negedge clk);
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = (stall == 0);
      check("wr_awready", awready, 1);
      check("wr_wready", wready, 1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < stall; i++) begin
         check("wr_stall_bvalid", bvalid, 1);
         check("wr_stall_bresp", bresp, resp);
         check("wr_stall_ready", {awready, wready}, 0);
         @(negedge clk);
      end
      bready = 1'b1;
      check("wr_bvalid", bvalid, 1);
      check("wr_bresp", bresp, resp);
      @(negedge clk);
      check("wr_bvalid_drop", bvalid, 0);
      bready = 1'b0;
   endtask

   // Expected data comes from exp_q; RREADY held low for 'stall' cycles after RVALID.
   task automatic do_read(input logic [31:0] a, input logic [1:0] resp, input int stall);
      logic [31:0] exp_d;
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      @(negedge clk);
      araddr = a; arvalid = 1'b1; rready = (stall == 0);
      check("rd_arready", arready, 1);
      @(negedge clk);
      arvalid = 1'b0;
      for (int i = 0; i < stall; i++) begin
         check("rd_stall_rvalid", rvalid, 1);
         check("rd_stall_rdata", rdata, exp_d);
         check("rd_stall_arready", arready, 0);
         @(negedge clk);
      end
      rready = 1'b1;
      check("rd_rvalid", rvalid, 1);
      check("rd_rdata", rdata, exp_d);
      check("rd_rresp", rresp, resp);
      @(negedge clk);
      check("rd_rvalid_drop", rvalid, 0);
      rready = 1'b0;
   endtask

   // Split write: one half first, the other half three cycles later.
   task automatic split_write(input logic addr_first, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bready = 1'b1;
      if (addr_first) begin awaddr = a; awvalid = 1'b1; end
      else begin wdata = d; wvalid = 1'b1; end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         awvalid = 1'b0; wvalid = 1'b0;
         check("split_awready", awready, addr_first ? 0 : 1);
         check("split_wready", wready, addr_first ? 1 : 0);
         check("split_bvalid", bvalid, 0);
      end
      @(negedge clk);
      if (addr_first) begin wdata = d; wvalid = 1'b1; end
      else begin awaddr = a; awvalid = 1'b1; end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      check("split_bvalid_set", bvalid, 1);
      check("split_bresp", bresp, 0);
      @(negedge clk);
      check("split_bvalid_drop", bvalid, 0);
      bready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_readys", {awready, wready, arready}, 0);
      check("rst_valids", {bvalid, rvalid}, 0);
      check("rst_resps", {bresp, rresp}, 0);
      check("rst_rdata", rdata, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_readys", {awready, wready, arready}, 3'b111);

      // Basic write and read.
      do_write(32'h1010, 32'hDEAD_BEEF, 2'b00, 0);
      exp_q.push_back(32'hDEAD_BEEF);
      do_read(32'h1010, 2'b00, 0);
      exp_q.push_back(32'hDEAD_BEEF);
      do_read(32'h1013, 2'b00, 0);

      // Split writes in both orders.
      split_write(1'b0, 32'h1020, 32'h1234_5678);
      split_write(1'b1, 32'h1024, 32'hCAFE_F00D);
      exp_q.push_back(32'h1234_5678);
      do_read(32'h1020, 2'b00, 0);
      exp_q.push_back(32'hCAFE_F00D);
      do_read(32'h1024, 2'b00, 0);

      // Back-pressure on B and R.
      do_write(32'h1030, 32'hA5A5_5A5A, 2'b00, 5);
      exp_q.push_back(32'hA5A5_5A5A);
      do_read(32'h1030, 2'b00, 5);

      // Write commit and read of the same word on one edge.
      do_write(32'h1040, 32'h1111_1111, 2'b00, 0);
      @(negedge clk);
      awaddr = 32'h1040; wdata = 32'h2222_2222; araddr = 32'h1040;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("coll_bvalid", bvalid, 1);
      check("coll_rvalid", rvalid, 1);
      check("coll_rdata_old", rdata, 32'h1111_1111);
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      exp_q.push_back(32'h2222_2222);
      do_read(32'h1040, 2'b00, 0);

      // Range boundaries.
      do_write(32'h1000, 32'h0BAD_F00D, 2'b00, 0);
      do_write(32'h13FC, 32'h5555_AAAA, 2'b00, 0);
`ifdef AXI_SRAM_RANGE_CHECK_EN
      do_write(32'h1400, 32'h9999_9999, 2'b10, 0);
      do_write(32'h0FFC, 32'h7777_7777, 2'b10, 0);
      exp_q.push_back(32'h0);
      do_read(32'h1400, 2'b10, 0);
      exp_q.push_back(32'h0BAD_F00D);
      do_read(32'h1000, 2'b00, 0);
      exp_q.push_back(32'h5555_AAAA);
      do_read(32'h13FC, 2'b00, 0);
`else
      do_write(32'h1400, 32'h9999_9999, 2'b00, 0);
      do_write(32'h0FFC, 32'h7777_7777, 2'b00, 0);
      exp_q.push_back(32'h9999_9999);
      do_read(32'h1000, 2'b00, 0);
      exp_q.push_back(32'h7777_7777);
      do_read(32'h13FC, 2'b00, 0);
`endif

      // Reset with a half-accepted write and a pending read response.
      do_write(32'h1050, 32'hABCD_0123, 2'b00, 0);
      @(negedge clk);
      awaddr = 32'h1050; awvalid = 1'b1; araddr = 32'h1050; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; arvalid = 1'b0;
      check("mid_rvalid_pending", rvalid, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_readys", {awready, wready, arready}, 0);
      check("mid_rst_valids", {bvalid, rvalid}, 0);
      check("mid_rst_rdata", rdata, 0);
      @(negedge clk);
      rst = 1'b0;
      wdata = 32'hFFFF_FFFF; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("mid_no_bvalid", bvalid, 0);
         check("mid_no_rvalid", rvalid, 0);
         @(negedge clk);
      end
      bready = 1'b0;
      exp_q.push_back(32'hABCD_0123);
      do_read(32'h1050, 2'b00, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
